neuron_mac: RTL and testbench
=============================

Name: neuron_mac

Overview:
Sequential multiply-accumulate neuron core. It consumes N_INPUTS signed input/weight pairs one per accepted cycle, adds a signed bias, and saturates the result to 16 bits. It produces the 16-bit pre-activation sum plus a one-cycle ready strobe. It sits directly upstream of the ReLU activation stage, which samples sum when ready is high.

Parameters:
N_INPUTS, 4, number of x/w pairs accumulated per neuron evaluation (legal range 1..255)
DATA_W, 8, width of signed input x and signed weight w (two's complement)
ACC_W, 24, internal signed accumulator width (must be at least 2*DATA_W + clog2(N_INPUTS) + 1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low; one clock, async assert
start  input  1  begin a new evaluation; sampled only in IDLE
bias  input  16  signed bias; sampled on the cycle start is accepted
in_valid  input  1  x/w pair valid this cycle
x  input  DATA_W  signed activation input
w  input  DATA_W  signed weight
clear  input  1  synchronous abort; returns to IDLE, sum unchanged
in_ready  output  1  high in ACC; a pair is accepted when in_valid && in_ready
busy  output  1  high in ACC and DONE
sum  output  16  signed saturated result; held until the next DONE
ready  output  1  one-cycle strobe; sum is valid when ready is high

Behaviour:
- Reset (rst_n=0, async): state=IDLE, acc=0, count=0, sum=16'h0000, ready=0, in_ready=0, busy=0.
- FSM states: IDLE, ACC, DONE.
- IDLE: in_ready=0. When start=1: acc <= sign-extend(bias) to ACC_W, count <= 0, go to ACC.
- ACC: in_ready=1. Each accepted pair does acc <= acc + sxt(x*w) and count <= count+1.
  - Product is a full 2*DATA_W signed product, sign-extended to ACC_W.
  - No intermediate saturation; ACC_W guarantees no wrap.
  - When the pair accepted is the one with count == N_INPUTS-1, go to DONE.
  - in_valid=0 cycles are bubbles: no state change and no timeout.
- DONE (one cycle): sum <= sat16(acc final), ready=1, in_ready=0. Next state is IDLE.
  - ready is registered, so it asserts the cycle after the last pair is accepted.
  - Latency from the last accepted pair to ready is 1 clock.
- sat16 rule: acc > 32767 gives 16'h7FFF; acc < -32768 gives 16'h8000; otherwise acc[15:0].
- sum changes only on the DONE edge. Downstream may sample it any time after ready.
- start is ignored outside IDLE, with no side effects.
- start in the same cycle as DONE is ignored. A new start is accepted at the earliest the cycle after ready.
- clear=1 in ACC or DONE: go to IDLE next edge, ready not asserted, sum keeps its old value, acc and count reset to 0. clear has priority over pair acceptance and over start.
- Async reset mid-evaluation discards the partial accumulation. Outputs return to reset values immediately.
- N_INPUTS=1: one accepted pair goes straight to DONE.

Test Plan:
- Basic: N=4, bias=10, (x,w)=(2,5),(3,6),(-1,7),(4,-2) back-to-back -> ready high exactly 1 cycle, 1 clk after 4th pair; sum=16'h0017 (23).
- Positive saturation: bias=0, four pairs (127,127) -> acc=64516; sum=16'h7FFF. Negative: four pairs (-128,127) -> acc=-65024; sum=16'h8000.
- Bubbles: same vectors as Basic with in_valid low 2 cycles between each pair -> sum=16'h0017; ready does not rise before the 4th accepted pair.
- Protocol: start pulsed during ACC and during DONE -> ignored, bias not reloaded, result unchanged. clear after 2 pairs -> IDLE, no ready, sum retains previous 16'h0017. Next full run with bias=-5 and all x=0 -> sum=16'hFFFB.
- Reset: rst_n low mid-ACC (async, between clock edges) -> sum=0, ready=0, in_ready=0 immediately. After release, a fresh Basic run gives 16'h0017.
- Sequential runs: two evaluations back-to-back, with start the cycle after ready -> second result correct, no carry-over of acc.

Source files
------------

// File: rtl/neuron_mac_if.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac_if
// Description : Handshake/data bundle between a neuron_mac core and its
//               producer/consumer. The master modport drives start, bias,
//               operand pairs and clear; the slave modport is the MAC core.
// Revision    : 1.0 - initial release
// ============================================================================
interface neuron_mac_if #(
    parameter int DATA_W = 8
);
    logic                     start;
    logic signed [15:0]       bias;
    logic                     in_valid;
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] w;
    logic                     clear;
    logic                     in_ready;
    logic                     busy;
    logic [15:0]              sum;
    logic                     ready;

    modport master (
        output start, bias, in_valid, x, w, clear,
        input  in_ready, busy, sum, ready
    );

    modport slave (
        input  start, bias, in_valid, x, w, clear,
        output in_ready, busy, sum, ready
    );
endinterface
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac
// Description : Sequential multiply-accumulate neuron. Loads a signed bias on
//               start, accumulates N_INPUTS signed x*w products (one per
//               accepted pair), then publishes the 16-bit saturated sum with a
//               one-cycle ready strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac #(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    neuron_mac_if.slave bus
);

    localparam int                      c_prod_w  = 2 * DATA_W;
    localparam int                      c_cnt_w   = 8;
    localparam logic [c_cnt_w-1:0]      c_last    = c_cnt_w'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] c_pos_max = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] c_neg_min = ACC_W'(-32768);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [c_cnt_w-1:0]        count_q, count_d;
    logic [15:0]               sum_q, sum_d;
    logic                      ready_q, ready_d;
    logic                      in_ready_q, in_ready_d;
    logic                      busy_q, busy_d;

    logic signed [c_prod_w-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic signed [ACC_W-1:0]    w_bias_ext;

    // Clamp the wide accumulator into the signed 16-bit output range.
    function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] a);
        logic [15:0] r;
        if (a > c_pos_max) begin
            r = 16'h7FFF;
        end else if (a < c_neg_min) begin
            r = 16'h8000;
        end else begin
            r = a[15:0];
        end
        return r;
    endfunction

    // Datapath: full-width signed product and the candidate accumulator value.
    always_comb begin
        w_prod     = c_prod_w'(bus.x) * c_prod_w'(bus.w);
        w_prod_ext = {{(ACC_W - c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
        w_acc_next = acc_q + w_prod_ext;
        w_bias_ext = {{(ACC_W - 16){bus.bias[15]}}, bus.bias};
    end

    // Next-state logic; clear outranks both start and pair acceptance.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        sum_d      = sum_q;
        ready_d    = 1'b0;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;

        if (bus.clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        acc_d   = w_bias_ext;
                        count_d = '0;
                        state_d = S_ACC;
                    end
                end
                S_ACC: begin
                    if (bus.in_valid) begin
                        acc_d   = w_acc_next;
                        count_d = count_q + 1'b1;
                        if (count_q == c_last) begin
                            // Result and strobe are registered together so
                            // sum is already valid while ready is high.
                            sum_d   = sat16(w_acc_next);
                            ready_d = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        in_ready_d = (state_d == S_ACC);
        busy_d     = (state_d == S_ACC) || (state_d == S_DONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            sum_q      <= 16'h0000;
            ready_q    <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            ready_q    <= ready_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.sum      = sum_q;
    assign bus.ready    = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_mac
// Description : Self-checking bench for neuron_mac: vector table plus
//               hand-written protocol, clear and reset sequences. Expected
//               sums are queued when a run starts and checked on ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_mac;

    logic clk;
    logic rst_n;

    neuron_mac_if #(.DATA_W(8)) bus ();

    neuron_mac #(
        .N_INPUTS (4),
        .DATA_W   (8),
        .ACC_W    (24)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0]      bias;
        logic [3:0][7:0]  xs;
        logic [3:0][7:0]  ws;
        int               gap;
        logic [15:0]      exp;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] sb_q[$];
    vec_t        vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int b, input int x0, input int x1, input int x2, input int x3,
                                input int w0, input int w1, input int w2, input int w3,
                                input int g, input int e);
        vec_t v;
        v.bias  = 16'(b);
        v.xs[0] = 8'(x0); v.xs[1] = 8'(x1); v.xs[2] = 8'(x2); v.xs[3] = 8'(x3);
        v.ws[0] = 8'(w0); v.ws[1] = 8'(w1); v.ws[2] = 8'(w2); v.ws[3] = 8'(w3);
        v.gap   = g;
        v.exp   = 16'(e);
        return v;
    endfunction

    // Scoreboard consumer: every ready strobe must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 32'(bus.sum), 32'hFFFF_FFFF);
            end else begin
                check("sum", 32'(bus.sum), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full evaluation; poke pulses start in ACC and in DONE with a bogus bias.
    task automatic run_vec(input vec_t v, input bit poke);
        sb_q.push_back(v.exp);
        bus.bias  = v.bias;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("in_ready_acc", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < v.gap; g++) begin
                bus.in_valid = 1'b0;
                step();
                check("bubble_no_ready", 32'(bus.ready), 32'd0);
            end
            bus.in_valid = 1'b1;
            bus.x        = v.xs[i];
            bus.w        = v.ws[i];
            if (poke && i == 1) begin
                bus.start = 1'b1;
                bus.bias  = 16'h1234;
            end
            step();
            bus.start    = 1'b0;
            bus.in_valid = 1'b0;
            if (i < 3) check("early_ready", 32'(bus.ready), 32'd0);
            else       check("ready_latency", 32'(bus.ready), 32'd1);
        end
        if (poke) begin
            bus.start = 1'b1;
            bus.bias  = 16'h4321;
        end
        step();
        bus.start = 1'b0;
        check("ready_pulse", 32'(bus.ready), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        if (poke) begin
            step();
            check("start_in_done_ignored", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        vecs.push_back(mk(10,     2, 3, -1, 4,       5, 6, 7, -2,         0, 'h0017));
        vecs.push_back(mk(0,      127, 127, 127, 127, 127, 127, 127, 127, 0, 'h7FFF));
        vecs.push_back(mk(0,      -128, -128, -128, -128, 127, 127, 127, 127, 0, 'h8000));
        vecs.push_back(mk(10,     2, 3, -1, 4,       5, 6, 7, -2,         2, 'h0017));
        vecs.push_back(mk(32767,  1, 0, 0, 0,        1, 0, 0, 0,          0, 'h7FFF));
        vecs.push_back(mk(-32768, -1, 0, 0, 0,       1, 0, 0, 0,          1, 'h8000));
        vecs.push_back(mk(32000,  100, -50, 0, 0,    10, 10, 0, 0,        0, 'h7EF4));
        vecs.push_back(mk(-100,   -7, -8, 5, -3,     9, -6, -4, -11,      1, 'hFF9A));

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.bias     = '0;
        bus.in_valid = 1'b0;
        bus.x        = '0;
        bus.w        = '0;
        bus.clear    = 1'b0;
        repeat (2) step();
        check("rst_sum", 32'(bus.sum), 32'h0);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Table-driven runs, back to back (each start lands the cycle after ready).
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], 1'b0);
        end

        // Start pulses in ACC and DONE must not reload bias or restart.
        run_vec(vecs[0], 1'b1);

        // Clear after two pairs: no ready, previous sum retained.
        bus.bias  = 16'd10;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.x        = vecs[0].xs[i];
            bus.w        = vecs[0].ws[i];
            step();
        end
        bus.clear    = 1'b1;
        bus.x        = 8'sd1;
        bus.w        = 8'sd1;
        step();
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        check("clear_busy", 32'(bus.busy), 32'd0);
        check("clear_in_ready", 32'(bus.in_ready), 32'd0);
        check("clear_sum_kept", 32'(bus.sum), 32'h0017);
        repeat (4) step();
        run_vec(mk(-5, 0, 0, 0, 0, 3, -7, 9, 100, 0, 'hFFFB), 1'b0);

        // Asynchronous reset between edges in the middle of ACC.
        bus.bias  = 16'd500;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.x        = 8'sd50;
            bus.w        = 8'sd50;
            step();
        end
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sum", 32'(bus.sum), 32'h0);
        check("arst_ready", 32'(bus.ready), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_vec(vecs[0], 1'b0);

        // Back-to-back sequential runs: no carry-over between evaluations.
        run_vec(mk(0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 'h0004), 1'b0);
        run_vec(mk(-3, 2, 2, 0, 0, -1, 1, 0, 0, 0, 'hFFFD), 1'b0);

        repeat (3) step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
